booth_seq_multiplier: RTL and testbench

Sequential radix-4 Booth multiplier that sits directly downstream of Booth_Encoder. Each cycle it feeds one overlapping multiplier bit-triple to the encoder and accumulates the returned partial product (PP) and SIGN correction into a running product. It is the core multiply stage of the Barrett modular-multiplication datapath (a·b, q·M products), with a valid/ready handshake on both sides.

---
 rtl/barrett_pkg.sv | 29 ++
 rtl/Booth_Encoder.sv | 44 ++++
 rtl/booth_seq_multiplier.sv | 111 +++++++++++
 tb/tb_booth_seq_multiplier.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_pkg.sv
// Shared types and sizing helpers for the Barrett datapath multipliers.
// BOOTH_MUL_SIGNED_EN selects two's-complement operands for the Booth stage.
package barrett_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Guard bits above the 2N-bit product so shifted partial products never wrap early.
    localparam int ACC_GUARD = 2;

`ifdef BOOTH_MUL_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    // Unsigned operands need one extra triple to cover the zero-padded MSBs.
    function automatic int iter_count(input int n, input bit signed_flag);
        return signed_flag ? n / 2 : n / 2 + 1;
    endfunction

    function automatic int acc_width(input int n);
        return 2 * n + ACC_GUARD;
    endfunction

endpackage

// File: rtl/Booth_Encoder.sv
// Radix-4 Booth encoder: maps one multiplier bit-triple to a multiple of y.
// Negative multiples are returned as the bitwise inverse with sign=1; the
// consumer adds sign back in. BOOTH_MUL_SIGNED_EN sign-extends y for +y.
module Booth_Encoder #(
    parameter int n = 8
) (
    input  logic [n-1:0] y,
    input  logic         x_high,
    input  logic         x,
    input  logic         x_low,
    output logic [n:0]   pp,
    output logic         sign
);

    logic [n:0] one_y;
    logic [n:0] two_y;

`ifdef BOOTH_MUL_SIGNED_EN
    assign one_y = {y[n-1], y};
`else
    assign one_y = {1'b0, y};
`endif
    assign two_y = {y, 1'b0};

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        pp   = '0;
        sign = 1'b0;
        case ({x_high, x, x_low})
            3'b001, 3'b010: pp = one_y;
            3'b011:         pp = two_y;
            3'b100: begin
                pp   = ~two_y;
                sign = 1'b1;
            end
            3'b101, 3'b110: begin
                pp   = ~one_y;
                sign = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, one bit-triple per clock, valid/ready on both sides.
// BOOTH_MUL_SIGNED_EN switches to two's-complement operands (N/2 iterations).
module booth_seq_multiplier
    import barrett_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int ITER  = iter_count(N, SIGNED_BUILD);
    localparam int ACC_W = acc_width(N);
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int B_W   = N + 3;

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     a_reg;
    logic [B_W-1:0]   b_reg;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] pp_ext;
    logic [ACC_W-1:0] term;
    logic [CNT_W-1:0] iter;
    logic [N:0]       pp;
    logic             pp_sign;
    logic             ext_bit;
    logic             last_iter;
    logic [1:0]       b_pad;

    // b_reg[2:0] always holds the current triple {b[2i+1], b[2i], b[2i-1]}.
    Booth_Encoder #(.n(N)) u_encoder (
        .y      (a_reg),
        .x_high (b_reg[2]),
        .x      (b_reg[1]),
        .x_low  (b_reg[0]),
        .pp     (pp),
        .sign   (pp_sign)
    );

`ifdef BOOTH_MUL_SIGNED_EN
    assign b_pad   = {2{b[N-1]}};
    assign ext_bit = pp[N];
`else
    // Unsigned magnitudes can reach 2a, so the encoder's sign flag is the true sign.
    assign b_pad   = 2'b00;
    assign ext_bit = pp_sign;
`endif

    always_comb begin
        pp_ext    = {{(ACC_W - N - 1){ext_bit}}, pp};
        term      = (pp_ext + ACC_W'(pp_sign)) << {iter, 1'b0};
        acc_next  = acc + term;
        last_iter = (iter == CNT_W'(ITER - 1));
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: state-holding blocks use non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            iter    <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= a;
                    b_reg <= {b_pad, b, 1'b0};
                    acc   <= '0;
                    iter  <= '0;
                end
                RUN: begin
                    acc   <= acc_next;
                    b_reg <= b_reg >> 2;
                    iter  <= iter + CNT_W'(1);
                    if (last_iter) product <= acc_next[2*N-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier: directed vectors, backpressure,
// mid-run reset and 1000 random pairs with random out_ready stalls.
module tb_booth_seq_multiplier;

    localparam int N = 8;
    localparam int W = 2 * N;
`ifdef BOOTH_MUL_SIGNED_EN
    localparam bit SGN  = 1'b1;
    localparam int ITER = N / 2;
`else
    localparam bit SGN  = 1'b0;
    localparam int ITER = N / 2 + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] product;

    booth_seq_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] prod;
        int           exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   hold_ready  = 1'b0;
    bit   stall_en    = 1'b0;
    bit   popped      = 1'b0;
    bit   prev_valid  = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: plain integer product of the operands, reduced to 2N bits.
    function automatic logic [W-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        longint sx, sy, p;
        sx = SGN ? longint'($signed(x)) : longint'(x);
        sy = SGN ? longint'($signed(y)) : longint'(y);
        p  = sx * sy;
        return p[W-1:0];
    endfunction

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [W-1:0] exp);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            bound_expired("in_ready");
            return;
        end
        a        = x;
        b        = y;
        in_valid = 1'b1;
        sb.push_back('{prod: exp, exp_cyc: cyc + 1 + ITER});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() > 0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            bound_expired("drain");
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: owns out_ready, compares every presented product against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                popped     = 1'b0;
                out_ready  = 1'b0;
            end else begin
                if (popped) begin
                    check("release", W'({out_valid, in_ready}), W'(2'b01));
                    popped = 1'b0;
                end else if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", W'(1), W'(0));
                    end else begin
                        if (!prev_valid) check("latency", W'(cyc), W'(sb[0].exp_cyc));
                        check("product", product, sb[0].prod);
                        check("in_ready_busy", W'(in_ready), W'(0));
                    end
                end
                prev_valid = out_valid;
                out_ready  = hold_ready ? 1'b0 : (stall_en ? ($urandom_range(0, 2) != 0) : 1'b1);
                if (out_valid && out_ready && sb.size() > 0) begin
                    void'(sb.pop_front());
                    popped = 1'b1;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] da[4];
    logic [N-1:0] db[4];
    logic [W-1:0] dp[4];

    initial begin
        int waited;
        logic [N-1:0] x;
        logic [N-1:0] y;

`ifdef BOOTH_MUL_SIGNED_EN
        da = '{8'hA9, 8'h80, 8'hFF, 8'h7F};
        db = '{8'h03, 8'h80, 8'hFF, 8'h80};
        dp = '{16'hFEFB, 16'h4000, 16'h0001, 16'hC080};
`else
        da = '{8'hA9, 8'hFF, 8'h00, 8'hA9};
        db = '{8'h0B, 8'hFF, 8'hA9, 8'h00};
        dp = '{16'h0743, 16'hFE01, 16'h0000, 16'h0000};
`endif

        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_product", product, '0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            send(da[i], db[i], dp[i]);
            drain();
        end

        // Backpressure: product held, new operands ignored while DONE.
        hold_ready = 1'b1;
        send(8'hA9, 8'h0B, ref_mul(8'hA9, 8'h0B));
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) bound_expired("stall_valid");
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 8'hFF;
            b        = 8'hFF;
        end
        @(negedge clk);
        in_valid   = 1'b0;
        hold_ready = 1'b0;
        drain();

        // Reset two iterations into RUN aborts the operation.
        send(8'hA9, 8'h0B, ref_mul(8'hA9, 8'h0B));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_product", product, '0);
        check("abort_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(8'h03, 8'h05, 16'h000F);
        drain();

        stall_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = N'($urandom);
            y = N'($urandom);
            case ($urandom_range(0, 9))
                0: x = '0;
                1: y = '1;
                2: x = {1'b1, {(N - 1){1'b0}}};
                default: ;
            endcase
            send(x, y, ref_mul(x, y));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
